// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// select codes and the scoreboard slot record with its match helpers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        HAZ_STALL,
        BR_FLUSH
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Slots hold register indices at a fixed width; REG_W must not exceed it.
    localparam int MAX_REG_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [MAX_REG_W-1:0] rd;
        logic [MAX_REG_W-1:0] rs;
        logic [MAX_REG_W-1:0] rt;
        logic                 uses_rs;
        logic                 uses_rt;
        logic                 wr;
        logic                 ld;
    } slot_t;

    function automatic logic slot_writes(input slot_t s, input logic [MAX_REG_W-1:0] idx);
        return s.valid && s.wr && (s.rd != '0) && (s.rd == idx);
    endfunction

    function automatic logic slot_feeds(input slot_t producer, input slot_t consumer);
        return consumer.valid &&
               ((consumer.uses_rs && slot_writes(producer, consumer.rs)) ||
                (consumer.uses_rt && slot_writes(producer, consumer.rt)));
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot record of in-flight instructions (EX, MEM, WB) that shifts with
// the pipeline and reports whether the EX or MEM occupant feeds the ID instruction.
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  freeze,
    input  logic  bubble,
    input  slot_t id_slot,
    output slot_t ex_slot,
    output slot_t mem_slot,
    output slot_t wb_slot,
    output logic  ex_hit,
    output logic  mem_hit
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else if (!freeze) begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= bubble ? '0 : id_slot;
        end
    end

    assign ex_hit  = slot_feeds(ex_slot, id_slot);
    assign mem_hit = slot_feeds(mem_slot, id_slot);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: stall/flush/bubble decode beside the ID stage.
// Define PIPE_FWD_EN to enable EX operand forwarding (load-use stalls only).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W     = 6,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles
);

    slot_t      id_slot;
    slot_t      ex_slot;
    slot_t      mem_slot;
    slot_t      wb_slot;
    logic       ex_hit;
    logic       mem_hit;
    logic       hazard;
    logic       stall_now;
    state_t     state;
    logic [2:0] flush_cnt;

    // An invalid ID instruction becomes an all-zero bubble record.
    always_comb begin
        id_slot = '0;
        if (id_valid) begin
            id_slot.valid   = 1'b1;
            id_slot.rd      = MAX_REG_W'(id_rd);
            id_slot.rs      = MAX_REG_W'(id_rs);
            id_slot.rt      = MAX_REG_W'(id_rt);
            id_slot.uses_rs = id_uses_rs;
            id_slot.uses_rt = id_uses_rt;
            id_slot.wr      = id_reg_write;
            id_slot.ld      = id_mem_read;
        end
    end

    hazard_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .freeze   (mem_busy),
        .bubble   (idex_bubble),
        .id_slot  (id_slot),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot),
        .ex_hit   (ex_hit),
        .mem_hit  (mem_hit)
    );

`ifdef PIPE_FWD_EN
    logic unused_sb;

    assign hazard    = ex_hit && ex_slot.ld;
    assign unused_sb = ^{ex_slot, mem_slot, wb_slot, mem_hit};

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (ex_slot.valid) begin
            if (slot_writes(mem_slot, ex_slot.rs))
                fwd_a = FWD_EXMEM;
            else if (slot_writes(wb_slot, ex_slot.rs))
                fwd_a = FWD_MEMWB;
            if (slot_writes(mem_slot, ex_slot.rt))
                fwd_b = FWD_EXMEM;
            else if (slot_writes(wb_slot, ex_slot.rt))
                fwd_b = FWD_MEMWB;
        end
    end
`else
    logic unused_sb;

    // WB is not checked: the register file writes before it is read.
    assign hazard    = ex_hit || mem_hit;
    assign fwd_a     = FWD_RF;
    assign fwd_b     = FWD_RF;
    assign unused_sb = ^{ex_slot, mem_slot, wb_slot, FWD_EXMEM, FWD_MEMWB};
`endif

    assign stall_now = hazard && !mem_busy && !br_taken && (state != BR_FLUSH);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (mem_busy) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
        end else if (br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state == BR_FLUSH) begin
            ifid_flush = 1'b1;
        end else if (stall_now) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // A taken branch restarts the squash window even while already flushing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            flush_cnt    <= '0;
            stall_cycles <= '0;
        end else if (!mem_busy) begin
            if (br_taken) begin
                state     <= BR_FLUSH;
                flush_cnt <= 3'(FLUSH_CYC);
            end else if (state == BR_FLUSH) begin
                if (flush_cnt <= 3'd1) begin
                    state     <= RUN;
                    flush_cnt <= '0;
                end else begin
                    flush_cnt <= flush_cnt - 3'd1;
                end
            end else if (stall_now) begin
                state <= HAZ_STALL;
                if (stall_cycles != '1)
                    stall_cycles <= stall_cycles + CNT_W'(1);
            end else begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against an instruction-level
// model of the pipeline (list of in-flight instructions, distance-based hazard rules).
module tb_pipe_hazard_ctrl;

    localparam int REG_W     = 6;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             br_taken;
    logic             mem_busy;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cycles;

    pipe_hazard_ctrl #(
        .REG_W     (REG_W),
        .FLUSH_CYC (FLUSH_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .br_taken     (br_taken),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int rd;
        int rs;
        int rt;
        bit urs;
        bit urt;
        bit wr;
        bit ld;
    } instr_t;

    // pipe[0] is one stage ahead of ID (EX), pipe[1] two ahead, pipe[2] three ahead
    instr_t   pipe [3];
    int       flushLeft;
    int       stallCount;
    int       assertCount = 0;
    int       failCount   = 0;
    bit       lastHold;
    bit [4:0] lastCtrl;

    function automatic instr_t makeInstr(bit v, int rd, int rs, int rt, bit urs, bit urt, bit wr, bit ld);
        instr_t i;
        i.valid = v;
        i.rd    = rd;
        i.rs    = rs;
        i.rt    = rt;
        i.urs   = urs;
        i.urt   = urt;
        i.wr    = wr;
        i.ld    = ld;
        return i;
    endfunction

    function automatic instr_t randInstr();
        instr_t i;
        i.valid = ($urandom_range(0, 7) != 0);
        i.rd    = $urandom_range(0, 7);
        i.rs    = $urandom_range(0, 7);
        i.rt    = $urandom_range(0, 7);
        i.urs   = ($urandom_range(0, 3) != 0);
        i.urt   = ($urandom_range(0, 1) != 0);
        i.wr    = ($urandom_range(0, 3) != 0);
        i.ld    = i.wr && ($urandom_range(0, 2) == 0);
        return i;
    endfunction

    function automatic bit produces(instr_t p, int r);
        return p.valid && p.wr && (p.rd != 0) && (p.rd == r);
    endfunction

    // ID must wait if an older instruction whose result is not yet reachable writes one of its sources
    function automatic bit mustWait(instr_t id);
        if (!id.valid)
            return 1'b0;
        for (int d = 0; d < 2; d++) begin
`ifdef PIPE_FWD_EN
            if (d != 0 || !pipe[d].ld)
                continue;
`endif
            if ((id.urs && produces(pipe[d], id.rs)) || (id.urt && produces(pipe[d], id.rt)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Operand source for the instruction in EX: 2 = one stage older, 1 = two stages older, 0 = regfile
    function automatic int fwdSel(int r);
`ifdef PIPE_FWD_EN
        if (!pipe[0].valid)
            return 0;
        if (produces(pipe[1], r))
            return 2;
        if (produces(pipe[2], r))
            return 1;
`endif
        return 0 * r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < 3; k++)
            pipe[k] = makeInstr(0, 0, 0, 0, 0, 0, 0, 0);
        flushLeft  = 0;
        stallCount = 0;
        lastHold   = 1'b0;
    endtask

    task automatic driveInputs(instr_t id, bit br, bit busy);
        id_valid     = id.valid;
        id_rd        = REG_W'(id.rd);
        id_rs        = REG_W'(id.rs);
        id_rt        = REG_W'(id.rt);
        id_uses_rs   = id.urs;
        id_uses_rt   = id.urt;
        id_reg_write = id.wr;
        id_mem_read  = id.ld;
        br_taken     = br;
        mem_busy     = busy;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        driveInputs(makeInstr(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearModel();
    endtask

    // One clock of stimulus: drive, check outputs against the model, then advance the model
    task automatic applyStimulus(instr_t id, bit br, bit busy);
        bit [4:0] expCtrl;
        bit       stall;
        int       expFwd;
        @(negedge clk);
        driveInputs(id, br, busy);
        #1;
        stall = 1'b0;
        if (busy)
            expCtrl = 5'b00000;
        else if (br)
            expCtrl = 5'b11111;
        else if (flushLeft > 0)
            expCtrl = 5'b11110;
        else if (mustWait(id)) begin
            expCtrl = 5'b00101;
            stall   = 1'b1;
        end else
            expCtrl = 5'b11100;
        expFwd = fwdSel(pipe[0].rs) * 4 + fwdSel(pipe[0].rt);
        lastCtrl = {pc_en, ifid_en, idex_en, ifid_flush, idex_bubble};
        checkOutput("ctrl", 32'(lastCtrl), 32'(expCtrl));
        checkOutput("fwd", 32'({fwd_a, fwd_b}), 32'(expFwd));
        checkOutput("stallCycles", 32'(stall_cycles), 32'(stallCount));
        lastHold = !expCtrl[3];
        if (!busy) begin
            if (stall && stallCount < CNT_MAX)
                stallCount++;
            if (br)
                flushLeft = FLUSH_CYC;
            else if (flushLeft > 0)
                flushLeft--;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (br || stall || !id.valid) ? makeInstr(0, 0, 0, 0, 0, 0, 0, 0) : id;
        end
    endtask

    task automatic issue(instr_t id);
        applyStimulus(id, 1'b0, 1'b0);
        for (int k = 0; k < 8 && lastHold; k++)
            applyStimulus(id, 1'b0, 1'b0);
        checkOutput("issueBound", 32'(lastHold), 32'(0));
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++)
            applyStimulus(makeInstr(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        instr_t cur;
        int     base;
        int     expDelta;
        int     flushSeen;
        int     bubbleSeen;

        rst_n = 1'b0;
        driveInputs(makeInstr(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        clearModel();
        doReset();
        idle(2);

        // ALU result consumed by the very next instruction
        base = stallCount;
`ifdef PIPE_FWD_EN
        expDelta = 0;
`else
        expDelta = 2;
`endif
        issue(makeInstr(1, 3, 1, 2, 1, 1, 1, 0));
        issue(makeInstr(1, 4, 3, 1, 1, 0, 1, 0));
        idle(3);
        checkOutput("addStalls", 32'(stall_cycles), 32'(base + expDelta));

        // Load result consumed by the very next instruction
        base = stallCount;
`ifdef PIPE_FWD_EN
        expDelta = 1;
`else
        expDelta = 2;
`endif
        issue(makeInstr(1, 5, 1, 0, 1, 0, 1, 1));
        issue(makeInstr(1, 6, 5, 2, 1, 1, 1, 0));
        idle(3);
        checkOutput("loadUseStalls", 32'(stall_cycles), 32'(base + expDelta));

        // Taken branch: flush window and single bubble
        flushSeen  = 0;
        bubbleSeen = 0;
        applyStimulus(makeInstr(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
        flushSeen  += int'(lastCtrl[1]);
        bubbleSeen += int'(lastCtrl[0]);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(makeInstr(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
            flushSeen  += int'(lastCtrl[1]);
            bubbleSeen += int'(lastCtrl[0]);
        end
        checkOutput("brFlushCycles", 32'(flushSeen), 32'(FLUSH_CYC + 1));
        checkOutput("brBubbles", 32'(bubbleSeen), 32'(1));

        // Memory wait held for four cycles in the middle of a load-use stall
        applyStimulus(makeInstr(1, 6, 0, 0, 0, 0, 1, 1), 1'b0, 1'b0);
        applyStimulus(makeInstr(1, 2, 6, 0, 1, 0, 1, 0), 1'b0, 1'b0);
        base = stallCount;
        for (int k = 0; k < 4; k++)
            applyStimulus(makeInstr(1, 2, 6, 0, 1, 0, 1, 0), 1'b0, 1'b1);
        checkOutput("busyHold", 32'(stall_cycles), 32'(base));
        issue(makeInstr(1, 2, 6, 0, 1, 0, 1, 0));
        idle(3);

        // Writes to r0 never create a dependency
        base = stallCount;
        issue(makeInstr(1, 0, 1, 2, 1, 1, 1, 1));
        issue(makeInstr(1, 3, 0, 0, 1, 1, 1, 0));
        idle(3);
        checkOutput("r0NoStall", 32'(stall_cycles), 32'(base));

        // Enough load-use pairs to drive the counter into saturation
        for (int k = 0; k < 20; k++) begin
            issue(makeInstr(1, 7, 0, 0, 0, 0, 1, 1));
            issue(makeInstr(1, 1, 7, 7, 1, 1, 1, 0));
        end
        idle(3);
        checkOutput("saturate", 32'(stall_cycles), 32'(CNT_MAX));

        // Reset while stalled: stale producer must be forgotten
        applyStimulus(makeInstr(1, 2, 0, 0, 0, 0, 1, 1), 1'b0, 1'b0);
        applyStimulus(makeInstr(1, 3, 2, 0, 1, 0, 1, 0), 1'b0, 1'b0);
        doReset();
        applyStimulus(makeInstr(1, 3, 2, 0, 1, 0, 1, 0), 1'b0, 1'b0);
        checkOutput("resetNoStale", 32'({pc_en, ifid_en, idex_en, idex_bubble}), 32'(4'b1110));
        checkOutput("resetCounter", 32'(stall_cycles), 32'(0));
        idle(3);

        // Randomized traffic; ID holds its instruction whenever IF/ID is disabled
        cur = randInstr();
        for (int n = 0; n < 900; n++) begin
            if (n % 300 == 299)
                doReset();
            applyStimulus(cur, $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
            if (!lastHold)
                cur = randInstr();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
